// File: rtl/apb_master_interface.sv
// APB requester for the I2C register block.
// Takes one command at a time over a valid/ready handshake, runs the APB
// SETUP/ACCESS sequence, and returns read data or a timeout error through a
// single-cycle response pulse.
module apb_master_interface #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk_i,
    input  logic                  preset_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic                  pwrite_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Timeout limit as an 8-bit value; zero disables the abort entirely.
    localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];

    // Saturating 8-bit increment so a disabled timeout never wraps the counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

    state_t     state_r;
    logic [7:0] tmo_cnt_r;
    logic [7:0] tmo_cnt_inc_s;
    logic       timeout_hit_s;

    // Ready only while idle; held low for as long as reset is asserted.
    assign cmd_ready_o = (state_r == ST_IDLE) && !preset_i;

    // Next wait count and whether this un-ready ACCESS cycle exhausts the budget.
    always_comb begin
        tmo_cnt_inc_s = sat_inc(tmo_cnt_r);
        if (TIMEOUT_LIMIT != 8'd0) begin
            timeout_hit_s = (tmo_cnt_inc_s == TIMEOUT_LIMIT);
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Transfer sequencer: command capture, APB phases, response pulse, timeout.
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state_r     <= ST_IDLE;
            tmo_cnt_r   <= 8'd0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= {ADDR_WIDTH{1'b0}};
            pwdata_o    <= {DATA_WIDTH{1'b0}};
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= {DATA_WIDTH{1'b0}};
        end else begin
            rsp_valid_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        paddr_o  <= cmd_addr_i;
                        pwrite_o <= cmd_write_i;
                        pwdata_o <= cmd_wdata_i;
                        psel_o   <= 1'b1;
                        state_r  <= ST_SETUP;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    penable_o <= 1'b1;
                    state_r   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready_i) begin
                        // A ready slave wins even when the budget expires this cycle.
                        rsp_rdata_o <= pwrite_o ? {DATA_WIDTH{1'b0}} : prdata_i;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        tmo_cnt_r   <= 8'd0;
                        state_r     <= ST_IDLE;
                    end else if (timeout_hit_s) begin
                        rsp_rdata_o <= {DATA_WIDTH{1'b0}};
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        tmo_cnt_r   <= 8'd0;
                        state_r     <= ST_IDLE;
                    end else begin
                        tmo_cnt_r   <= tmo_cnt_inc_s;
                        state_r     <= ST_ACCESS;
                    end
                end
                default: begin
                    psel_o    <= 1'b0;
                    penable_o <= 1'b0;
                    tmo_cnt_r <= 8'd0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_interface.sv
// Self-checking bench for apb_master_interface: directed scenarios plus random
// transfers, checked against a register-map reference model and cycle timing
// computed from the transfer rules (2 + ACCESS length, ACCESS capped at 16).
module tb_apb_master_interface;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] paddr;
    logic       pwrite;
    logic       psel;
    logic       penable;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem   [256];
    logic [7:0] slave_mem [256];

    logic       h_w;
    logic [7:0] h_a;
    logic [7:0] h_d;

    apb_master_interface #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk_i     (clk),
        .preset_i   (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_write_i(cmd_write),
        .cmd_addr_i (cmd_addr),
        .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .paddr_o    (paddr),
        .pwrite_o   (pwrite),
        .psel_o     (psel),
        .penable_o  (penable),
        .pwdata_o   (pwdata),
        .prdata_i   (prdata),
        .pready_i   (pready)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer. waits = number of ACCESS cycles the slave holds pready low
    // (255 = never ready). hold=1 keeps cmd_valid high with h_* while busy.
    task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input int waits, input logic hold);
        int         cyc;
        int         acc;
        int         exp_acc;
        logic       got;
        logic       exp_err;
        logic [7:0] exp_rd;
        exp_err = (waits >= 16);
        exp_acc = exp_err ? 16 : waits + 1;
        exp_rd  = (w || exp_err) ? 8'h00 : ref_mem[a];

        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        check("ready_in_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        if (hold) begin
            cmd_write = h_w;
            cmd_addr  = h_a;
            cmd_wdata = h_d;
        end else begin
            cmd_valid = 1'b0;
        end
        check("setup_psel",    32'(psel),      32'd1);
        check("setup_penable", 32'(penable),   32'd0);
        check("setup_paddr",   32'(paddr),     32'(a));
        check("setup_pwrite",  32'(pwrite),    32'(w));
        check("setup_pwdata",  32'(pwdata),    32'(d));
        check("setup_ready",   32'(cmd_ready), 32'd0);
        pready = 1'($urandom_range(0, 1));
        prdata = 8'($urandom);
        acc = 0;
        got = 1'b0;
        cyc = 1;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                check("access_psel",    32'(psel),      32'd1);
                check("access_penable", 32'(penable),   32'd1);
                check("access_paddr",   32'(paddr),     32'(a));
                check("access_pwrite",  32'(pwrite),    32'(w));
                check("access_pwdata",  32'(pwdata),    32'(d));
                check("busy_ready",     32'(cmd_ready), 32'd0);
                acc++;
                pready = (acc > waits);
                prdata = slave_mem[paddr];
                if (pready && pwrite) slave_mem[paddr] = pwdata;
            end
        end
        check("rsp_seen",    32'(got),       32'd1);
        check("rsp_latency", 32'(cyc),       32'(2 + exp_acc));
        check("rsp_err",     32'(rsp_err),   32'(exp_err));
        check("rsp_rdata",   32'(rsp_rdata), 32'(exp_rd));
        check("idle_psel",   32'(psel),      32'd0);
        check("idle_penable",32'(penable),   32'd0);
        check("idle_ready",  32'(cmd_ready), 32'd1);
        if (!hold) cmd_valid = 1'b0;
        pready = 1'($urandom_range(0, 1));
        prdata = 8'($urandom);
        if (w && !exp_err) ref_mem[a] = d;
    endtask

    initial begin
        int wsel;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        prdata    = 8'h00;
        pready    = 1'b0;
        h_w = 1'b0;
        h_a = 8'h00;
        h_d = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]   = 8'($urandom);
            slave_mem[i] = ref_mem[i];
        end

        // Reset values.
        #1;
        check("rst_ready",   32'(cmd_ready), 32'd0);
        check("rst_psel",    32'(psel),      32'd0);
        check("rst_penable", 32'(penable),   32'd0);
        check("rst_rsp",     32'(rsp_valid), 32'd0);
        check("rst_paddr",   32'(paddr),     32'd0);
        check("rst_pwdata",  32'(pwdata),    32'd0);
        check("rst_rdata",   32'(rsp_rdata), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        // Directed: write, read-back, wait states, timeout and its boundary.
        txn(1'b1, 8'h05, 8'h3C, 0, 1'b0);
        txn(1'b0, 8'h05, 8'h00, 0, 1'b0);
        txn(1'b1, 8'h22, 8'hA5, 3, 1'b0);
        txn(1'b0, 8'h22, 8'h00, 255, 1'b0);
        txn(1'b0, 8'h22, 8'h00, 15, 1'b0);
        txn(1'b1, 8'h30, 8'h77, 16, 1'b0);
        txn(1'b0, 8'h30, 8'h00, 1, 1'b0);

        // Command held while busy, then back-to-back accept on the response cycle.
        h_w = 1'b0; h_a = 8'h05; h_d = 8'h11;
        txn(1'b1, 8'h05, 8'hC3, 2, 1'b1);
        txn(h_w, h_a, h_d, 0, 1'b0);

        // Random traffic on a small address window so reads hit prior writes.
        for (int n = 0; n < 25; n++) begin
            wsel = int'($urandom_range(0, 9));
            txn(1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom),
                (wsel == 9) ? 255 : (wsel == 8) ? 15 : wsel % 5, 1'($urandom));
            cmd_valid = 1'b0;
        end

        // Reset in the middle of ACCESS.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44; cmd_wdata = 8'h00;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        pready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            pready = 1'b0;
        end
        check("pre_rst_access", 32'({psel, penable}), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_psel",    32'(psel),      32'd0);
        check("mid_rst_penable", 32'(penable),   32'd0);
        check("mid_rst_rsp",     32'(rsp_valid), 32'd0);
        check("mid_rst_ready",   32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_rsp2", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_rsp",   32'(rsp_valid), 32'd0);
        check("post_rst_psel",  32'(psel),      32'd0);
        txn(1'b0, 8'h05, 8'h00, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
